// File: rtl/sar_scan_ctrl.sv
// SAR ADC scan sequencer: walks the enabled channels in ascending order and
// resolves bits 9..0 per channel. All outputs are registered.
module sar_scan_ctrl #(
  parameter int unsigned SAMPLE_CYCLES = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] chan_mask,
  output logic [7:0] ADC,
  output logic [9:0] bitctrl,
  output logic       sample_hold,
  output logic       wr_en,
  output logic [2:0] chan,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StSample, StBit, StDone} state_e;

  localparam logic [3:0] SampleLast = 4'(SAMPLE_CYCLES - 1);
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] bit_q, bit_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] chan_d;
  logic [2:0] first_chan, next_chan;
  logic       next_found;
  logic       in_scan;

  // Lowest set channel of the incoming mask, and next set channel above the current one.
  always_comb begin
    first_chan = '0;
    next_chan  = '0;
    next_found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (chan_mask[i]) first_chan = 3'(i);
      if (mask_q[i] && (3'(i) > chan)) begin
        next_chan  = 3'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    chan_d  = chan;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d = chan_mask;
          cnt_d  = '0;
          if (chan_mask != 8'h00) begin
            state_d = StSample;
            chan_d  = first_chan;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSample: begin
        if (cnt_q == SampleLast) begin
          state_d = StBit;
          bit_d   = 4'd9;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StBit: begin
        if (cnt_q == SettleLast) begin
          cnt_d = '0;
          if (bit_q == 4'd0) begin
            if (next_found) begin
              state_d = StSample;
              chan_d  = next_chan;
            end else begin
              state_d = StDone;
              chan_d  = '0;
            end
          end else begin
            bit_d = bit_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      chan_d  = '0;
      bit_d   = '0;
      cnt_d   = '0;
    end
  end

  assign in_scan = (state_d == StSample) || (state_d == StBit);

  // Outputs are derived from next state so the registered values line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      chan        <= '0;
      ADC         <= '0;
      bitctrl     <= '0;
      sample_hold <= 1'b0;
      wr_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      chan        <= chan_d;
      ADC         <= in_scan ? (8'd1 << chan_d) : 8'd0;
      bitctrl     <= (state_d == StBit) ? (10'd1 << bit_d) : 10'd0;
      sample_hold <= (state_d == StSample);
      wr_en       <= (state_d == StBit) && (cnt_d == SettleLast);
      busy        <= (state_d != StIdle);
      done        <= (state_d == StDone);
    end
  end

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed bench for sar_scan_ctrl at default parameters; outputs compared
// every cycle against a cycle-indexed reference of the scan timeline.
module tb_sar_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] chan_mask;
  logic [7:0] ADC;
  logic [9:0] bitctrl;
  logic       sample_hold;
  logic       wr_en;
  logic [2:0] chan;
  logic       busy;
  logic       done;

  int n_total = 0;
  int n_pass  = 0;

  logic [24:0] obs;
  assign obs = {ADC, bitctrl, sample_hold, wr_en, chan, busy, done};

  sar_scan_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .chan_mask   (chan_mask),
    .ADC         (ADC),
    .bitctrl     (bitctrl),
    .sample_hold (sample_hold),
    .wr_en       (wr_en),
    .chan        (chan),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected {ADC,bitctrl,sample_hold,wr_en,chan,busy,done} in cycle c after start accept.
  // Defaults: 4 sample cycles, then 10 bits x 3 cycles = 34 cycles per channel.
  function automatic logic [24:0] exp_out(input logic [7:0] m, input int c);
    int n, k, p, q, ch, b, j;
    logic [24:0] res;
    res = '0;
    n = $countones(m);
    if (n == 0) begin
      if (c == 1) res = 25'b11;
    end else if (c == 34 * n + 1) begin
      res = 25'b11;
    end else if (c >= 1 && c <= 34 * n) begin
      k  = (c - 1) / 34;
      p  = (c - 1) % 34;
      ch = 0;
      j  = 0;
      for (int i = 0; i < 8; i++) begin
        if (m[i]) begin
          if (j == k) ch = i;
          j++;
        end
      end
      res[24:17] = 8'd1 << ch;
      res[4:2]   = 3'(ch);
      res[1]     = 1'b1;
      if (p < 4) begin
        res[6] = 1'b1;
      end else begin
        q = p - 4;
        b = 9 - q / 3;
        res[16:7] = 10'd1 << b;
        res[5]    = (q % 3 == 2);
      end
    end
    return res;
  endfunction

  // Starts at the current negedge and checks cycles 1..ncyc; returns at negedge of ncyc.
  task automatic run_scan(input logic [7:0] m, input int ncyc, input int restart_at,
                          input string tag, output int wr_cnt, output int done_at);
    start     = 1'b1;
    chan_mask = m;
    @(negedge clk);
    wr_cnt  = 0;
    done_at = 0;
    for (int c = 1; c <= ncyc; c++) begin
      check(tag, 32'(obs), 32'(exp_out(m, c)));
      if (wr_en) wr_cnt++;
      if (done && done_at == 0) done_at = c;
      start = (c == restart_at);
      if (restart_at > 0 && c >= restart_at) chan_mask = 8'hFF;
      if (c < ncyc) @(negedge clk);
    end
    start = 1'b0;
  endtask

  int wr, dn;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    chan_mask = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'(obs), 32'd0);

    // First start in the first cycle out of reset, single channel 0
    rst_n = 1'b1;
    run_scan(8'h01, 37, 0, "m01", wr, dn);
    check("m01_done_cycle", dn, 35);
    check("m01_wr_count", wr, 10);

    // Channels 2,5,7
    run_scan(8'hA4, 105, 0, "mA4", wr, dn);
    check("mA4_done_cycle", dn, 103);
    check("mA4_wr_count", wr, 30);

    // Empty mask goes straight to DONE
    run_scan(8'h00, 4, 0, "m00", wr, dn);
    check("m00_done_cycle", dn, 1);
    check("m00_wr_count", wr, 0);

    // Restart with a new mask while busy is ignored
    run_scan(8'h24, 71, 10, "restart", wr, dn);
    check("restart_done_cycle", dn, 69);
    check("restart_wr_count", wr, 20);

    // Abort during BIT of channel 5
    run_scan(8'hA4, 50, 0, "abort_pre", wr, dn);
    check("abort_pre_chan", 32'(chan), 32'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outs", 32'(obs), 32'd0);
    run_scan(8'h01, 37, 0, "after_abort", wr, dn);
    check("after_abort_done_cycle", dn, 35);
    check("after_abort_wr_count", wr, 10);

    // Reset pulse mid-SAMPLE
    run_scan(8'h01, 2, 0, "rst_pre", wr, dn);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midsample_reset_outs", 32'(obs), 32'd0);
    run_scan(8'h01, 37, 0, "after_rst", wr, dn);
    check("after_rst_done_cycle", dn, 35);
    check("after_rst_wr_count", wr, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sar_scan_ctrl.md
SAR_SCAN_CTRL -- requirements
Module: sar_scan_ctrl

Interface
REQ-001 SHALL provide parameter SAMPLE_CYCLES, default 4, meaning sample/hold cycles per channel (legal range 1..15).
REQ-002 SHALL provide parameter SETTLE_CYCLES, default 2, meaning comparator settle cycles per bit before capture (legal range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: single-cycle scan request, honoured only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: terminates any scan in progress.
REQ-007 SHALL have port chan_mask, input, 8 bits: enabled ADC channels, sampled only when start is accepted.
REQ-008 SHALL have port ADC, output, 8 bits: one-hot select of the active ADC channel.
REQ-009 SHALL have port bitctrl, output, 10 bits: one-hot select of the SAR bit under resolution (bit 9 = MSB).
REQ-010 SHALL have port sample_hold, output, 1 bit: drives the track/hold of the active channel.
REQ-011 SHALL have port wr_en, output, 1 bit: one-cycle strobe marking the cycle in which the selected bit is captured.
REQ-012 SHALL have port chan, output, 3 bits: binary index of the active channel.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse on scan completion.

Function
REQ-015 SHALL implement states IDLE, SAMPLE, BIT, DONE.
REQ-016 IDLE: start=1 with chan_mask!=0 SHALL latch the mask, select the lowest set channel, and enter SAMPLE next cycle.
REQ-017 IDLE: start=1 with chan_mask==0 SHALL enter DONE next cycle with no SAMPLE/BIT cycles.
REQ-018 SAMPLE SHALL last exactly SAMPLE_CYCLES cycles with sample_hold=1, then enter BIT at bit 9.
REQ-019 BIT SHALL spend SETTLE_CYCLES+1 cycles per bit, wr_en=1 only on the last of those cycles, and bitctrl stable and one-hot for all of them.
REQ-020 Bit order SHALL be 9 down to 0; after the bit-0 wr_en the FSM SHALL move to the next higher set channel of the latched mask (entering SAMPLE) or to DONE if none remains.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 ADC SHALL equal one-hot(chan) in SAMPLE and BIT, and 0 in IDLE and DONE; bitctrl SHALL be 0 outside BIT; sample_hold SHALL be 0 outside SAMPLE.
REQ-023 Per-channel duration SHALL be SAMPLE_CYCLES + 10*(SETTLE_CYCLES+1) cycles (34 at defaults); done SHALL be high in cycle 34*N+1 after the start-accept cycle, N = popcount(mask).
REQ-024 start while busy SHALL be ignored; chan_mask changes while busy SHALL not affect the scan.
REQ-025 abort=1 in any non-IDLE state SHALL return to IDLE next cycle with all outputs 0 and no done pulse; abort in IDLE SHALL have no effect; abort takes priority over start in the same cycle.
REQ-026 Channels not set in the latched mask SHALL never appear on ADC or chan.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, latched mask 0, and ADC=0, bitctrl=0, sample_hold=0, wr_en=0, chan=0, busy=0, done=0, from any state, including mid-bit.
REQ-029 The first start SHALL be accepted in the first cycle with rst_n=1.

Verification
REQ-030 start, mask=8'h01, defaults -> sample_hold 4 cycles with ADC=8'h01; then bitctrl 10'h200..10'h001, each 3 cycles, wr_en on every 3rd; done in cycle 35.
REQ-031 start, mask=8'hA4 -> channels visited 2,5,7 in order, ADC 8'h04/8'h20/8'h80, 30 wr_en pulses total, done in cycle 103.
REQ-032 start, mask=8'h00 -> done in cycle 1, busy high for that cycle only, no wr_en.
REQ-033 start again in cycle 10 of a scan, with mask changed to 8'hFF -> ignored; original scan completes unchanged.
REQ-034 abort during BIT of channel 5 of mask 8'hA4 -> next cycle all outputs 0, busy 0, no done; new start accepted the following cycle.
REQ-035 rst_n=0 for one cycle mid-SAMPLE -> all outputs 0 next cycle; the next start behaves per REQ-030.
